// File: rtl/spi_duty_receiver_pkg.sv
// Shared constants, FSM state type and the duty clamp helper for the SPI duty receiver.
// DUTY_W is also consumed by the downstream PWM stage.
package spi_duty_receiver_pkg;

   localparam int FRAME_BITS = 16;
   localparam int HDR_W      = 5;
   localparam int DUTY_W     = 11;
   localparam int CNT_W      = 5;
   localparam int ERR_W      = 8;

   localparam logic [HDR_W-1:0]  HEADER       = 5'b10100;
   localparam logic [DUTY_W-1:0] DUTY_MAX_DEF = 11'd2047;
   localparam logic [CNT_W-1:0]  CNT_ZERO     = 5'd0;
   localparam logic [CNT_W-1:0]  CNT_ONE      = 5'd1;
   localparam logic [CNT_W-1:0]  CNT_FRAME    = 5'd16;
   localparam logic [CNT_W-1:0]  CNT_SAT      = 5'd17;
   localparam logic [ERR_W-1:0]  ERR_CNT_MAX  = 8'd255;
   localparam logic [ERR_W-1:0]  ERR_CNT_ONE  = 8'd1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] duty,
                                                    input logic [DUTY_W-1:0] duty_max);
      return (duty > duty_max) ? duty_max : duty;
   endfunction

endpackage

// File: rtl/spi_duty_receiver_if.sv
// SPI pins toward the receiver plus the duty/strobe/error outputs toward the PWM stage.
interface spi_duty_receiver_if;
   import spi_duty_receiver_pkg::*;

   logic              sclk;
   logic              mosi;
   logic              cs_n;
   logic [DUTY_W-1:0] duty_out;
   logic              duty_valid;
   logic              frame_err;
   logic [ERR_W-1:0]  err_count;

   modport master (
      output sclk, mosi, cs_n,
      input  duty_out, duty_valid, frame_err, err_count
   );

   modport slave (
      input  sclk, mosi, cs_n,
      output duty_out, duty_valid, frame_err, err_count
   );

endinterface

// File: rtl/spi_duty_receiver_sync_edge.sv
// Two-flop synchroniser followed by an edge register; level is taken from the edge stage
// so data sampled here lines up with edges detected on a sibling instance.
module spi_duty_receiver_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic lvl_o,
   output logic rise_o,
   output logic fall_o
);

   logic [2:0] sync_q;

   // synchroniser chain and edge-detect stage
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= 3'b000;
      end else begin
         sync_q <= {sync_q[1:0], d_i};
      end
   end

   assign lvl_o  = sync_q[2];
   assign rise_o = sync_q[1] & ~sync_q[2];
   assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_duty_receiver.sv
// SPI mode-0 slave: deserialises 16-bit header+duty frames, validates header and bit count,
// clamps the duty and presents it with a one-cycle strobe; rejected frames bump a saturating counter.
module spi_duty_receiver
   import spi_duty_receiver_pkg::*;
#(
   parameter logic [DUTY_W-1:0] DUTY_MAX = DUTY_MAX_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   spi_duty_receiver_if.slave bus
);

   logic sclk_rise_s, cs_rise_s, cs_fall_s, mosi_s;
   logic sclk_lvl_s, sclk_fall_s, mosi_rise_s, mosi_fall_s, cs_lvl_s;
   logic unused_s;

   state_e                state_q;
   logic [FRAME_BITS-1:0] shreg_q;
   logic [CNT_W-1:0]      bit_cnt_q;
   logic [DUTY_W-1:0]     duty_out_q;
   logic                  duty_valid_q;
   logic                  frame_err_q;
   logic [ERR_W-1:0]      err_count_q;
   logic [DUTY_W-1:0]     duty_clamp_d;
   logic                  frame_ok_d;

   spi_duty_receiver_sync_edge u_sync_sclk (
      .clk(clk), .rst_n(rst_n), .d_i(bus.sclk),
      .lvl_o(sclk_lvl_s), .rise_o(sclk_rise_s), .fall_o(sclk_fall_s)
   );

   spi_duty_receiver_sync_edge u_sync_mosi (
      .clk(clk), .rst_n(rst_n), .d_i(bus.mosi),
      .lvl_o(mosi_s), .rise_o(mosi_rise_s), .fall_o(mosi_fall_s)
   );

   spi_duty_receiver_sync_edge u_sync_cs (
      .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n),
      .lvl_o(cs_lvl_s), .rise_o(cs_rise_s), .fall_o(cs_fall_s)
   );

   assign unused_s = ^{sclk_lvl_s, sclk_fall_s, mosi_rise_s, mosi_fall_s, cs_lvl_s};

   assign duty_clamp_d = clamp_duty(shreg_q[DUTY_W-1:0], DUTY_MAX);
   assign frame_ok_d   = (bit_cnt_q == CNT_FRAME) &&
                         (shreg_q[FRAME_BITS-1 -: HDR_W] == HEADER);

   // frame FSM with shift register, bit counter and registered result outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         shreg_q      <= {FRAME_BITS{1'b0}};
         bit_cnt_q    <= CNT_ZERO;
         duty_out_q   <= {DUTY_W{1'b0}};
         duty_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         err_count_q  <= {ERR_W{1'b0}};
      end else begin
         duty_valid_q <= 1'b0;
         frame_err_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cs_fall_s) begin
                  state_q   <= ST_SHIFT;
                  bit_cnt_q <= CNT_ZERO;
                  shreg_q   <= {FRAME_BITS{1'b0}};
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            // cs_rise wins over a coincident sclk_rise
            ST_SHIFT: begin
               if (cs_rise_s) begin
                  state_q <= ST_CHECK;
               end else if (sclk_rise_s) begin
                  shreg_q <= {shreg_q[FRAME_BITS-2:0], mosi_s};
                  if (bit_cnt_q != CNT_SAT) begin
                     bit_cnt_q <= bit_cnt_q + CNT_ONE;
                  end else begin
                     bit_cnt_q <= CNT_SAT;
                  end
               end else begin
                  state_q <= ST_SHIFT;
               end
            end
            ST_CHECK: begin
               state_q <= ST_IDLE;
               if (bit_cnt_q != CNT_ZERO) begin
                  if (frame_ok_d) begin
                     duty_out_q   <= duty_clamp_d;
                     duty_valid_q <= 1'b1;
                  end else begin
                     frame_err_q <= 1'b1;
                     if (err_count_q != ERR_CNT_MAX) begin
                        err_count_q <= err_count_q + ERR_CNT_ONE;
                     end else begin
                        err_count_q <= ERR_CNT_MAX;
                     end
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.duty_out   = duty_out_q;
   assign bus.duty_valid = duty_valid_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_count  = err_count_q;

endmodule
